// File: rtl/spi_slave_frontend_pkg.sv
// Shared types and constants for the SPI slave front end feeding the single-port RAM.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;

    function automatic logic is_shift_state(input state_e s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage

// File: rtl/spi_slave_frontend_if.sv
// SPI pins plus the RAM-side command/read-data handshake of the slave front end.
interface spi_slave_frontend_if #(
    parameter int DATA_W = 8
);
    logic              MOSI;
    logic              SS_n;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  MOSI, SS_n, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output MOSI, SS_n, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial shifter for RAM read data: MSB first, one bit per clk, MISO idles low.
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              done_o
);
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sreg_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              miso_q;

    // The MSB goes straight to MISO on load so it appears the cycle after tx_valid.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else if (load_i) begin
            miso_q <= data_i[DATA_W-1];
            sreg_q <= {data_i[DATA_W-2:0], 1'b0};
            cnt_q  <= CW'(DATA_W - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                miso_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                miso_q <= sreg_q[DATA_W-1];
                sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
                cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

    assign done_o = busy_q && (cnt_q == '0);
    assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave_frontend.sv
// SPI slave front end: frame FSM, MOSI deserialiser and read-address/read-data pairing.
module spi_slave_frontend
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_slave_frontend_if.slave  bus
);
    localparam int FW = DATA_W + 2;

    state_e          state_q;
    logic [FW-1:0]   rx_data_q;
    logic            rx_valid_q;
    logic [3:0]      bit_cnt_q;
    logic            rd_addr_seen_q;
    logic            rx_done_q;
    logic            tx_sent_q;

    logic            tx_load;
    logic            tx_clr;
    logic            tx_done;
    logic            tx_miso;

    // Only one serialisation per read-data frame, and only once its command word is out.
    assign tx_load = (state_q == READ_DATA) && rx_done_q && !tx_sent_q
                     && bus.tx_valid && !bus.SS_n;
    assign tx_clr  = (state_q != IDLE) && bus.SS_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            bit_cnt_q      <= '0;
            rd_addr_seen_q <= 1'b0;
            rx_done_q      <= 1'b0;
            tx_sent_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tx_clr) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!bus.SS_n) begin
                            state_q   <= CHK_CMD;
                            bit_cnt_q <= '0;
                            rx_done_q <= 1'b0;
                            tx_sent_q <= 1'b0;
                        end
                    end
                    CHK_CMD: begin
                        if (!bus.MOSI)          state_q <= WRITE;
                        else if (rd_addr_seen_q) state_q <= READ_DATA;
                        else                    state_q <= READ_ADD;
                    end
                    default: begin
                        if (is_shift_state(state_q) && !rx_done_q) begin
                            rx_data_q <= {rx_data_q[FW-2:0], bus.MOSI};
                            if (bit_cnt_q == 4'(FW - 1)) begin
                                rx_valid_q <= 1'b1;
                                rx_done_q  <= 1'b1;
                                if (state_q == READ_ADD) rd_addr_seen_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                        if (tx_load) tx_sent_q      <= 1'b1;
                        if (tx_done) rd_addr_seen_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tx_clr),
        .load_i (tx_load),
        .data_i (bus.tx_data),
        .miso_o (tx_miso),
        .done_o (tx_done)
    );

    assign bus.MISO     = tx_miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed frame vectors and hand-written corner sequences for the SPI slave front end.
module tb_spi_slave_frontend;
    import spi_pkg::*;

    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_frontend_if #(.DATA_W(DATA_W)) bus();

    spi_slave_frontend #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       c;
        logic [9:0] bits;
        int         nbits;
        logic [7:0] txd;
        logic       exp_rxv;
        logic [9:0] exp_rx;
        logic [7:0] exp_miso;
        logic       exp_seen;
    } vec_t;

    vec_t vecs[12];

    int total = 0;
    int bad   = 0;
    int rxv_seen, rxv_edge, edge_n, miso_stray;
    logic [9:0] rxv_data;
    logic [7:0] got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        edge_n++;
        if (bus.rx_valid === 1'b1) begin
            if (rxv_seen == 0) rxv_edge = edge_n;
            rxv_seen++;
            rxv_data = bus.rx_data;
        end
    endtask

    // Drop SS_n with the command bit, then shift n frame bits MSB first.
    task automatic shift_in(input logic c, input logic [9:0] bits, input int n);
        rxv_seen   = 0;
        edge_n     = 0;
        miso_stray = 0;
        bus.SS_n   = 1'b0;
        bus.MOSI   = c;
        cyc();
        cyc();
        for (int i = 0; i < n; i++) begin
            bus.MOSI = bits[9-i];
            cyc();
            if (bus.MISO !== 1'b0) miso_stray++;
        end
    endtask

    task automatic tx_phase(input logic [7:0] txd, input int delay, output logic [7:0] bits);
        repeat (delay) cyc();
        bus.tx_valid = 1'b1;
        bus.tx_data  = txd;
        cyc();
        bus.tx_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i < 7) cyc();
            bits[i] = bus.MISO;
        end
        cyc();
    endtask

    task automatic end_frame(input string tag);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        cyc();
        check({tag, "_idle"}, 32'(dut.state_q), 32'(IDLE));
        cyc();
    endtask

    task automatic run_frame(input vec_t v, input int k);
        string tag;
        logic [7:0] mb;
        tag = $sformatf("v%0d", k);
        shift_in(v.c, v.bits, v.nbits);
        if (v.nbits == 10) begin
            tx_phase(v.txd, 0, mb);
            check({tag, "_miso_byte"}, 32'(mb), 32'(v.exp_miso));
            check({tag, "_miso_after"}, 32'(bus.MISO), 32'd0);
            check({tag, "_rx_hold"}, 32'(bus.rx_data), 32'(v.exp_rx));
        end
        end_frame(tag);
        check({tag, "_rxv_count"}, 32'(rxv_seen), v.exp_rxv ? 32'd1 : 32'd0);
        if (v.exp_rxv) begin
            check({tag, "_rxv_edge"}, 32'(rxv_edge), 32'd12);
            check({tag, "_rx_data"}, 32'(rxv_data), 32'(v.exp_rx));
        end
        check({tag, "_miso_quiet"}, 32'(miso_stray), 32'd0);
        check({tag, "_rd_seen"}, 32'(dut.rd_addr_seen_q), 32'(v.exp_seen));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        c     bits                      n   txd    rxv   exp_rx    miso   seen
        vecs[0]  = '{1'b0, {CMD_WR_ADDR, 8'hA5}, 10, 8'h00, 1'b1, 10'h0A5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, {CMD_WR_DATA, 8'h3C}, 10, 8'h00, 1'b1, 10'h13C, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, {CMD_RD_ADDR, 8'h0F}, 10, 8'h77, 1'b1, 10'h20F, 8'h00, 1'b1};
        vecs[3]  = '{1'b1, {CMD_RD_DATA, 8'hAA}, 10, 8'hC3, 1'b1, 10'h3AA, 8'hC3, 1'b0};
        vecs[4]  = '{1'b0, 10'h155,               6, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, {CMD_WR_ADDR, 8'h5A}, 10, 8'h00, 1'b1, 10'h05A, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, {CMD_RD_DATA, 8'hFF}, 10, 8'hFF, 1'b1, 10'h3FF, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, {CMD_RD_DATA, 8'hC5}, 10, 8'h5A, 1'b1, 10'h3C5, 8'h5A, 1'b0};
        vecs[8]  = '{1'b0, {CMD_RD_ADDR, 8'hF0}, 10, 8'hFF, 1'b1, 10'h2F0, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, {CMD_RD_ADDR, 8'h81}, 10, 8'h00, 1'b1, 10'h281, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 10'h3FF,               9, 8'h00, 1'b0, 10'h000, 8'h00, 1'b1};
        vecs[11] = '{1'b1, {CMD_RD_DATA, 8'h00}, 10, 8'h81, 1'b1, 10'h300, 8'h81, 1'b0};

        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        rst          = 1'b1;
        repeat (3) cyc();
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_rxv", 32'(bus.rx_valid), 32'd0);
        check("rst_rxdata", 32'(bus.rx_data), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        rst = 1'b0;
        cyc();

        for (int k = 0; k < 12; k++) run_frame(vecs[k], k);

        // Reset lands while MISO shows bit 3 of a read-data transfer.
        run_frame(vecs[2], 20);
        shift_in(1'b1, {CMD_RD_DATA, 8'h11}, 10);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hBF;
        cyc();
        bus.tx_valid = 1'b0;
        check("rstmid_bit7", 32'(bus.MISO), 32'd1);
        repeat (4) cyc();
        check("rstmid_bit3", 32'(bus.MISO), 32'd1);
        rst      = 1'b1;
        bus.SS_n = 1'b1;
        cyc();
        check("rstmid_miso", 32'(bus.MISO), 32'd0);
        check("rstmid_rxv", 32'(bus.rx_valid), 32'd0);
        check("rstmid_state", 32'(dut.state_q), 32'(IDLE));
        check("rstmid_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        rst = 1'b0;
        cyc();

        // Early tx_valid during shifting is ignored; slow RAM; SS_n aborts mid-byte.
        run_frame(vecs[2], 21);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        shift_in(1'b1, {CMD_RD_DATA, 8'h42}, 10);
        bus.tx_valid = 1'b0;
        check("slow_rxv_count", 32'(rxv_seen), 32'd1);
        check("slow_miso_quiet", 32'(miso_stray), 32'd0);
        repeat (3) cyc();
        check("slow_wait_miso", 32'(bus.MISO), 32'd0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA0;
        cyc();
        bus.tx_valid = 1'b0;
        check("slow_bit7", 32'(bus.MISO), 32'd1);
        cyc();
        check("slow_bit6", 32'(bus.MISO), 32'd0);
        cyc();
        check("slow_bit5", 32'(bus.MISO), 32'd1);
        bus.SS_n = 1'b1;
        cyc();
        check("abort_miso", 32'(bus.MISO), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'(IDLE));
        check("abort_seen_kept", 32'(dut.rd_addr_seen_q), 32'd1);
        cyc();
        run_frame(vecs[11], 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
